// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for the EX stage: DIV/DIVU/REM/REMU, with
// optional early completion for divide-by-zero and signed overflow.
module div_sequencer #(
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [2:0] {IDLE, INIT, ITER, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        rem_op_q;   // 1: REM/REMU, 0: DIV/DIVU
  logic        neg1_q, neg2_q;
  logic [31:0] quot_q, rem_q, div_q, res_q;

  logic        signed_op;
  logic [31:0] abs1, abs2;
  logic        div_zero, sgn_ovf;
  logic [31:0] rem_sh, quot_sh;
  logic [32:0] diff;
  logic [31:0] early_res, fix_res;
  logic [31:0] q_fix, r_fix;

  always_comb begin
    signed_op = ~op_i[0];
    abs1      = (signed_op && rs1_i[31]) ? (32'd0 - rs1_i) : rs1_i;
    abs2      = (signed_op && rs2_i[31]) ? (32'd0 - rs2_i) : rs2_i;
    div_zero  = (div_q == '0);
    // Magnitudes 2^31 / 1 with both signs set only arise from 0x80000000 / -1.
    sgn_ovf   = neg1_q && neg2_q && (quot_q == 32'h8000_0000) && (div_q == 32'd1);
    rem_sh    = {rem_q[30:0], quot_q[31]};
    quot_sh   = {quot_q[30:0], 1'b0};
    diff      = {1'b0, rem_sh} - {1'b0, div_q};
  end

  always_comb begin
    q_fix = (neg1_q ^ neg2_q) ? (32'd0 - quot_q) : quot_q;
    r_fix = neg1_q ? (32'd0 - rem_q) : rem_q;
    // Zero divisor iterates to all-ones quotient; skip the sign fix there.
    if (div_zero && !rem_op_q)
      q_fix = '1;
    fix_res = rem_op_q ? r_fix : q_fix;
    if (div_zero)
      early_res = rem_op_q ? (neg1_q ? (32'd0 - quot_q) : quot_q) : '1;
    else
      early_res = rem_op_q ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) state_d = INIT;
        INIT: state_d = ((EARLY_OUT != 0) && (div_zero || sgn_ovf)) ? DONE : ITER;
        ITER: if (cnt_q == '0) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_op_q <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      res_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i && !flush_i) begin
          rem_op_q <= op_i[1];
          neg1_q   <= signed_op & rs1_i[31];
          neg2_q   <= signed_op & rs2_i[31];
          quot_q   <= abs1;
          div_q    <= abs2;
          rem_q    <= '0;
          cnt_q    <= 5'd31;
        end
        INIT: res_q <= early_res;
        ITER: begin
          if (!diff[32]) begin
            rem_q  <= diff[31:0];
            quot_q <= quot_sh | 32'd1;
          end else begin
            rem_q  <= rem_sh;
            quot_q <= quot_sh;
          end
          cnt_q <= cnt_q - 5'd1;
        end
        FIX: res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = done_o ? res_q : '0;
  assign stall_o  = start_i & ~done_o & ~flush_i;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: two instances (EARLY_OUT=1 and 0) share
// operand inputs; sel picks which one is started and observed.
module tb_div_sequencer;

  logic        clk, rst, start, sel, flush;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy1, stall1, done1, busy0, stall0, done0;
  logic [31:0] res1, res0;
  logic        start1, start0;
  logic        busy_s, stall_s, done_s;
  logic [31:0] res_s;
  int unsigned tests, fails;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  assign start1  = start & ~sel;
  assign start0  = start & sel;
  assign busy_s  = sel ? busy0  : busy1;
  assign stall_s = sel ? stall0 : stall1;
  assign done_s  = sel ? done0  : done1;
  assign res_s   = sel ? res0   : res1;

  div_sequencer #(.EARLY_OUT(1)) dut_eo (
    .clk(clk), .rst(rst), .start_i(start1), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .flush_i(flush), .busy_o(busy1), .stall_o(stall1), .done_o(done1), .result_o(res1)
  );

  div_sequencer #(.EARLY_OUT(0)) dut_it (
    .clk(clk), .rst(rst), .start_i(start0), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .flush_i(flush), .busy_o(busy0), .stall_o(stall0), .done_o(done0), .result_o(res0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the current cycle (FSM in IDLE, start already driven).
  task automatic wait_done(input logic [31:0] exp, input int exp_cyc, input string tag);
    int cyc;
    bit found;
    logic [31:0] a, b;
    cyc = 0; found = 0; a = rs1; b = rs2;
    while (!found && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        rs1 = ~a ^ 32'h1234_5678;  // operands must already be captured
        rs2 = b + 32'd3;
      end
      if (done_s) found = 1;
      else if (cyc == 5) begin
        chk({tag, "_stall_mid"}, {31'd0, stall_s}, 32'd1);
        chk({tag, "_res_mid"}, res_s, 32'd0);
      end
    end
    chk({tag, "_latency"}, found ? cyc : 32'hDEAD_BEEF, exp_cyc);
    chk({tag, "_result"}, res_s, exp);
    chk({tag, "_stall_done"}, {31'd0, stall_s}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_no_restart"}, {30'd0, busy_s, done_s}, 32'd0);
    start = 1'b0;
  endtask

  task automatic run_op(input bit s, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_cyc, input string tag);
    sel = s; op = o; rs1 = a; rs2 = b; start = 1'b1;
    wait_done(exp, exp_cyc, tag);
  endtask

  initial begin
    int cyc;
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; sel = 1'b0; flush = 1'b0;
    op = OP_DIV; rs1 = '0; rs2 = '0;
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_result", res1, 32'd0);
    chk("rst_stall_lo", {31'd0, stall1}, 32'd0);
    start = 1'b1; #1;
    chk("rst_stall_follows", {31'd0, stall1}, 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, OP_DIVU, 32'd100, 32'd7, 32'd14, 35, "divu_100_7");
    run_op(0, OP_REMU, 32'd100, 32'd7, 32'd2, 35, "remu_100_7");
    run_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, "div_m7_2");
    run_op(0, OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, "rem_m7_2");
    run_op(0, OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, "div_7_m2");
    run_op(0, OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 35, "rem_7_m2");
    run_op(0, OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "div_5_0_eo");
    run_op(0, OP_REMU, 32'd5, 32'd0, 32'd5, 2, "remu_5_0_eo");
    run_op(0, OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2, "rem_m5_0_eo");
    run_op(1, OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 35, "div_5_0_it");
    run_op(1, OP_REMU, 32'd5, 32'd0, 32'd5, 35, "remu_5_0_it");
    run_op(1, OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 35, "rem_m5_0_it");
    run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf_eo");
    run_op(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf_eo");
    run_op(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, "div_ovf_it");
    run_op(0, OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35, "divu_max_1");

    // Flush during ITER
    sel = 1'b0; op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    for (cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; #1;
    chk("flush_busy_before", {31'd0, busy1}, 32'd1);
    chk("flush_stall", {31'd0, stall1}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_busy_after", {31'd0, busy1}, 32'd0);
    chk("flush_done_after", {31'd0, done1}, 32'd0);
    @(posedge clk); #1;
    chk("flush_no_late_done", {30'd0, busy1, done1}, 32'd0);
    run_op(0, OP_DIVU, 32'd9, 32'd3, 32'd3, 35, "divu_9_3_post_flush");

    // Reset mid-operation with start held through release
    sel = 1'b0; op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", {31'd0, busy1}, 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_outputs", {30'd0, busy1, done1}, 32'd0);
    chk("mid_rst_result", res1, 32'd0);
    chk("mid_rst_stall", {31'd0, stall1}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done(32'd14, 35, "divu_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
